// File: rtl/sync_fifo_lvl_if.sv
// Handshake, status and configuration bundle for sync_fifo_lvl.
// The master side drives requests and thresholds; the slave side is the FIFO.
interface sync_fifo_lvl_if #(
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 4
);
    logic                 wr_en;
    logic [WIDTH-1:0]     wdata;
    logic                 rd_en;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [PTR_WIDTH:0]   level;
    logic [PTR_WIDTH:0]   af_thresh;
    logic [PTR_WIDTH:0]   ae_thresh;
    logic                 overflow;
    logic                 underflow;
    logic                 clr_err;

    modport master (
        output wr_en, wdata, rd_en, af_thresh, ae_thresh, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, af_thresh, ae_thresh, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with level count, programmable almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module sync_fifo_lvl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            res_n,
    sync_fifo_lvl_if.slave  bus
);
    localparam logic [PTR_WIDTH:0]   LVL_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   LVL_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = (PTR_WIDTH)'(1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 full, empty;
    logic                 wr_acc, rd_acc;
    logic [WIDTH-1:0]     head;

    assign empty  = (level_q == '0);
    assign full   = (level_q == LVL_FULL);
    // A write into a full FIFO is accepted when a read frees a slot on the same edge.
    assign rd_acc = bus.rd_en & ~empty;
    assign wr_acc = bus.wr_en & (~full | bus.rd_en);
    assign head   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = (bus.wr_en & ~wr_acc) | (overflow_q & ~bus.clr_err);
        underflow_d = (bus.rd_en & ~rd_acc) | (underflow_q & ~bus.clr_err);
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; level/pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= bus.wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rdata  = empty ? '0 : head;
    assign bus.rvalid = ~empty;
`else
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_acc;
        if (rd_acc) rdata_d = head;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= bus.af_thresh);
    assign bus.almost_empty = (level_q <= bus.ae_thresh);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Directed bench for sync_fifo_lvl (DEPTH 16, WIDTH 8); covers both read modes.
module tb_sync_fifo_lvl;
    logic clk;
    logic res_n;
    int   n_tests;
    int   n_fail;

    sync_fifo_lvl_if #(.WIDTH(8), .PTR_WIDTH(4)) bus ();

    sync_fifo_lvl #(.WIDTH(8), .DEPTH(16)) dut (
        .clk   (clk),
        .res_n (res_n),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en = 1'b1;
        bus.wdata = d;
        cycle();
        bus.wr_en = 1'b0;
    endtask

    // Pops one word and checks it where each read mode presents it.
    task automatic pop_check(input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk("pop_rvalid", 32'(bus.rvalid), 32'd1);
        chk("pop_rdata", 32'(bus.rdata), 32'(exp));
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
`else
        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        chk("pop_rvalid", 32'(bus.rvalid), 32'd1);
        chk("pop_rdata", 32'(bus.rdata), 32'(exp));
`endif
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        res_n         = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.wdata     = '0;
        bus.clr_err   = 1'b0;
        bus.af_thresh = 5'd12;
        bus.ae_thresh = 5'd3;

        #3;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_unf", 32'(bus.underflow), 32'd0);
        chk("rst_ae", 32'(bus.almost_empty), 32'd1);
        chk("rst_af", 32'(bus.almost_full), 32'd0);
        @(posedge clk);
        #1 res_n = 1'b1;

        // fill 0x00..0x0F; thresholds 12 / 3
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            chk("fill_level", 32'(bus.level), 32'(i + 1));
            chk("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 3));
            chk("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 12));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_empty", 32'(bus.empty), 32'd0);

        push(8'hFF);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_level", 32'(bus.level), 32'd16);

        bus.clr_err = 1'b1;
        cycle();
        bus.clr_err = 1'b0;
        chk("ovf_clr", 32'(bus.overflow), 32'd0);
        bus.clr_err = 1'b1;
        push(8'hEE);
        bus.clr_err = 1'b0;
        chk("ovf_set_wins", 32'(bus.overflow), 32'd1);
        bus.clr_err = 1'b1;
        cycle();
        bus.clr_err = 1'b0;
        chk("ovf_clr2", 32'(bus.overflow), 32'd0);

        // drain: rejected writes must not have disturbed contents
        for (int i = 0; i < 16; i++) begin
            pop_check(8'(i));
            chk("drain_level", 32'(bus.level), 32'(15 - i));
            chk("drain_ae", 32'(bus.almost_empty), 32'((15 - i) <= 3));
            chk("drain_af", 32'(bus.almost_full), 32'((15 - i) >= 12));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);

        bus.rd_en = 1'b1;
        cycle();
        bus.rd_en = 1'b0;
        chk("unf_set", 32'(bus.underflow), 32'd1);
        chk("unf_rvalid", 32'(bus.rvalid), 32'd0);
        chk("unf_level", 32'(bus.level), 32'd0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("unf_rdata", 32'(bus.rdata), 32'd0);
`else
        chk("unf_rdata_hold", 32'(bus.rdata), 32'h0F);
`endif
        bus.clr_err = 1'b1;
        cycle();
        bus.clr_err = 1'b0;
        chk("unf_clr", 32'(bus.underflow), 32'd0);

        // empty with simultaneous write and read
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        bus.wdata = 8'h40;
        cycle();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        chk("wr_rd_empty_level", 32'(bus.level), 32'd1);
        chk("wr_rd_empty_unf", 32'(bus.underflow), 32'd1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("wr_rd_empty_rvalid", 32'(bus.rvalid), 32'd1);
`else
        chk("wr_rd_empty_rvalid", 32'(bus.rvalid), 32'd0);
`endif
        bus.clr_err = 1'b1;
        cycle();
        bus.clr_err = 1'b0;

        for (int i = 1; i < 16; i++) push(8'(8'h40 + i));
        chk("refill_level", 32'(bus.level), 32'd16);

        // full streaming: 20 cycles of simultaneous write and read
        bus.wr_en = 1'b1;
        bus.rd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.wdata = 8'(8'h50 + i);
`ifdef SYNC_FIFO_FWFT_EN
            chk("stream_rdata", 32'(bus.rdata), 32'(8'h40 + i));
            cycle();
`else
            cycle();
            chk("stream_rdata", 32'(bus.rdata), 32'(8'h40 + i));
            chk("stream_rvalid", 32'(bus.rvalid), 32'd1);
`endif
            chk("stream_level", 32'(bus.level), 32'd16);
            chk("stream_ovf", 32'(bus.overflow), 32'd0);
        end
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;

        for (int i = 0; i < 9; i++) pop_check(8'(8'h54 + i));
        chk("pre_rst_level", 32'(bus.level), 32'd7);

        // asynchronous reset between edges
        #1 res_n = 1'b0;
        #1;
        chk("arst_level", 32'(bus.level), 32'd0);
        chk("arst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_full", 32'(bus.full), 32'd0);
        chk("arst_af", 32'(bus.almost_full), 32'd0);
        #1 res_n = 1'b1;
        cycle();

        push(8'hA5);
        chk("post_rst_level", 32'(bus.level), 32'd1);
        pop_check(8'hA5);
        chk("post_rst_empty", 32'(bus.empty), 32'd1);
        chk("post_rst_unf", 32'(bus.underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_lvl.md
SYNC_FIFO_LVL -- requirements
Module: sync_fifo_lvl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter PTR_WIDTH, default $clog2(DEPTH), read/write pointer width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 res_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  write request.
REQ-007 wdata  input  WIDTH  write data.
REQ-008 rd_en  input  1  read request.
REQ-009 rdata  output  WIDTH  read data.
REQ-010 rvalid  output  1  rdata holds a newly popped word.
REQ-011 full, empty  output  1 each  occupancy flags.
REQ-012 almost_full, almost_empty  output  1 each  threshold flags.
REQ-013 level  output  PTR_WIDTH+1  current entry count, 0..DEPTH.
REQ-014 af_thresh, ae_thresh  input  PTR_WIDTH+1 each  programmable thresholds.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 clr_err  input  1  synchronous clear of overflow/underflow.

Function
REQ-017 rd_acc = rd_en & ~empty; wr_acc = wr_en & (~full | rd_en); both use pre-edge flag values.
REQ-018 wr_acc stores wdata at wr_ptr; rd_acc reads entry at rd_ptr; each pointer advances by 1 on acceptance, wrapping DEPTH-1 -> 0.
REQ-019 level updates on the edge: +1 for write only, -1 for read only, unchanged for both or neither.
REQ-020 full = (level==DEPTH); empty = (level==0); both decoded from registered level, no combinational path from wr_en/rd_en.
REQ-021 almost_full = (level >= af_thresh); almost_empty = (level <= ae_thresh); unsigned compare, any threshold value legal.
REQ-022 Full with wr_en & rd_en: both accepted, level stays DEPTH, no overflow.
REQ-023 Empty with wr_en & rd_en: write accepted, read rejected, underflow set, level becomes 1.
REQ-024 overflow sets on wr_en & ~wr_acc; underflow sets on rd_en & ~rd_acc; each holds until clr_err; set wins over clr_err in the same cycle.
REQ-025 Rejected requests change no pointer, level or memory.
REQ-026 Registered read (default): rdata loads the popped word one edge after rd_acc; rvalid high for that one cycle; rdata otherwise holds its value.

Reset
REQ-027 res_n low immediately forces: pointers 0, level 0, rdata 0, rvalid 0, overflow 0, underflow 0; hence empty=1, full=0.
REQ-028 Memory array is not reset; contents are don't-care after reset.
REQ-029 Reset asserted mid-operation discards all stored data; first access after deassertion behaves as on an empty FIFO.

Configuration
REQ-030 Macro SYNC_FIFO_FWFT_EN selects first-word-fall-through read mode.
REQ-031 Defined: rdata = entry at rd_ptr whenever ~empty (0-cycle latency); rd_en acknowledges and pops the head; rvalid = ~empty.
REQ-032 Undefined: registered read per REQ-026; all other requirements are identical in both modes.

Verification
REQ-033 Reset, then 16 writes 0x00..0x0F -> full=1 and level=16 after the 16th edge; a 17th write sets overflow, data unchanged.
REQ-034 From full, 16 reads -> rdata 0x00..0x0F in order, each with rvalid one cycle after rd_en; empty=1 at end; one more read sets underflow.
REQ-035 af_thresh=12, ae_thresh=3, fill 0..16 -> almost_empty high for level<=3, almost_full high for level>=12.
REQ-036 Full, wr_en=rd_en=1 for 20 cycles -> level stays 16, no overflow, pointers wrap and output order is preserved.
REQ-037 overflow set, clr_err pulsed alone -> overflow 0 next cycle; clr_err with a rejected write in the same cycle -> overflow stays 1.
REQ-038 res_n pulsed low between edges with level=7 -> level, rvalid and flags clear without a clock edge; with SYNC_FIFO_FWFT_EN, first write 0xA5 appears on rdata the cycle after the write edge.
